// File: rtl/addsub_result_if.sv
// Handshake and data bundle between the adder/subtractor, the result stage
// and its downstream consumer.
interface addsub_result_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  IN_VALID;
    logic                  IN_READY;
    logic [DATA_WIDTH-1:0] S;
    logic                  CF;
    logic                  OF;
    logic                  SUB;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic [DATA_WIDTH-1:0] RESULT;
    logic [3:0]            FLAGS;

    modport slave (
        input  IN_VALID, S, CF, OF, SUB, OUT_READY,
        output IN_READY, OUT_VALID, RESULT, FLAGS
    );

    modport master (
        output IN_VALID, S, CF, OF, SUB, OUT_READY,
        input  IN_READY, OUT_VALID, RESULT, FLAGS
    );
endinterface

// File: rtl/addsub_result_stage.sv
// Registered result stage behind the adder/subtractor: derives NZCV-style
// flags, buffers two entries for full throughput, counts overflows.
module addsub_result_stage #(
    parameter int DATA_WIDTH     = 16,
    parameter int OVERFLOW_LOGIC = 1,
    parameter int COUNT_WIDTH    = 8
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    addsub_result_if.slave         bus,
    input  logic                   CLR_COUNT,
    output logic [COUNT_WIDTH-1:0] OF_COUNT
);
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } state_e;

    state_e                 state_q, state_d;
    logic                   in_ready_q, in_ready_d;
    logic [DATA_WIDTH-1:0]  main_res_q, main_res_d;
    logic [DATA_WIDTH-1:0]  skid_res_q, skid_res_d;
    logic [3:0]             main_flg_q, main_flg_d;
    logic [3:0]             skid_flg_q, skid_flg_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                   accept;
    logic                   emit;
    logic [3:0]             new_flg;
    logic [COUNT_WIDTH-1:0] cnt_max;

    assign cnt_max = '1;

    always_comb begin
        accept  = bus.IN_VALID & in_ready_q;
        emit    = (state_q != ST_EMPTY) & bus.OUT_READY;
        // Carry is inverted on subtract so CF reads as borrow.
        new_flg = {bus.S[DATA_WIDTH-1],
                   (bus.S == '0),
                   bus.CF ^ bus.SUB,
                   bus.OF & (OVERFLOW_LOGIC != 0)};

        state_d    = state_q;
        main_res_d = main_res_q;
        main_flg_d = main_flg_q;
        skid_res_d = skid_res_q;
        skid_flg_d = skid_flg_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d    = ST_ONE;
                    main_res_d = bus.S;
                    main_flg_d = new_flg;
                end
            end
            ST_ONE: begin
                if (accept && emit) begin
                    main_res_d = bus.S;
                    main_flg_d = new_flg;
                end else if (accept) begin
                    state_d    = ST_TWO;
                    skid_res_d = bus.S;
                    skid_flg_d = new_flg;
                end else if (emit) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (emit) begin
                    state_d    = ST_ONE;
                    main_res_d = skid_res_q;
                    main_flg_d = skid_flg_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        in_ready_d = (state_d != ST_TWO);

        cnt_d = cnt_q;
        if (CLR_COUNT) begin
            cnt_d = '0;
        end else if (accept && new_flg[0] && (cnt_q != cnt_max)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
            main_res_q <= '0;
            main_flg_q <= '0;
            skid_res_q <= '0;
            skid_flg_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_res_q <= main_res_d;
            main_flg_q <= main_flg_d;
            skid_res_q <= skid_res_d;
            skid_flg_q <= skid_flg_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.IN_READY  = in_ready_q;
    assign bus.OUT_VALID = (state_q != ST_EMPTY);
    assign bus.RESULT    = main_res_q;
    assign bus.FLAGS     = main_flg_q;
    assign OF_COUNT      = cnt_q;
endmodule

// File: tb/tb_addsub_result_stage.sv
// Directed bench for addsub_result_stage: flags, skid back-pressure,
// overflow counter saturation/clear and asynchronous reset.
module tb_addsub_result_stage;
    logic       CLK;
    logic       RST_N;
    logic       CLR_COUNT;
    logic [7:0] OF_COUNT;
    int         errors;
    int         checks;

    addsub_result_if #(.DATA_WIDTH(16)) bus ();

    addsub_result_stage #(
        .DATA_WIDTH(16),
        .OVERFLOW_LOGIC(1),
        .COUNT_WIDTH(8)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .bus(bus),
        .CLR_COUNT(CLR_COUNT),
        .OF_COUNT(OF_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic set_in(input logic v, input logic [15:0] s,
                          input logic cf, input logic of, input logic sub);
        bus.IN_VALID = v;
        bus.S        = s;
        bus.CF       = cf;
        bus.OF       = of;
        bus.SUB      = sub;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        CLR_COUNT = 1'b0;
        bus.OUT_READY = 1'b0;
        set_in(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        #3;
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL rst_out_valid got %b want 0", bus.OUT_VALID);
        end
        checks++;
        if (bus.IN_READY !== 1'b0) begin
            errors++; $display("FAIL rst_in_ready got %b want 0", bus.IN_READY);
        end
        checks++;
        if (bus.RESULT !== 16'h0 || bus.FLAGS !== 4'h0 || OF_COUNT !== 8'h0) begin
            errors++;
            $display("FAIL rst_values got res=%h flg=%b cnt=%0d want 0", bus.RESULT, bus.FLAGS, OF_COUNT);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            errors++; $display("FAIL rst_release_ready got %b want 1", bus.IN_READY);
        end
    endtask

    task automatic test_flags();
        logic [15:0] vs [3];
        logic        vc [3];
        logic        vo [3];
        logic        vb [3];
        logic [3:0]  ef [3];
        logic [7:0]  ec [3];
        vs[0] = 16'h8000; vc[0] = 1'b0; vo[0] = 1'b1; vb[0] = 1'b0; ef[0] = 4'b1001; ec[0] = 8'd1;
        vs[1] = 16'h0000; vc[1] = 1'b1; vo[1] = 1'b0; vb[1] = 1'b1; ef[1] = 4'b0100; ec[1] = 8'd1;
        vs[2] = 16'hFFFE; vc[2] = 1'b0; vo[2] = 1'b0; vb[2] = 1'b1; ef[2] = 4'b1010; ec[2] = 8'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            bus.OUT_READY = 1'b0;
            set_in(1'b1, vs[i], vc[i], vo[i], vb[i]);
            @(negedge CLK);
            set_in(1'b0, 16'h5A5A, 1'b1, 1'b1, 1'b0);
            checks++;
            if (bus.OUT_VALID !== 1'b1 || bus.RESULT !== vs[i]) begin
                errors++;
                $display("FAIL flags_result[%0d] got v=%b res=%h want v=1 res=%h", i, bus.OUT_VALID, bus.RESULT, vs[i]);
            end
            checks++;
            if (bus.FLAGS !== ef[i]) begin
                errors++; $display("FAIL flags_value[%0d] got %b want %b", i, bus.FLAGS, ef[i]);
            end
            checks++;
            if (OF_COUNT !== ec[i]) begin
                errors++; $display("FAIL flags_count[%0d] got %0d want %0d", i, OF_COUNT, ec[i]);
            end
            bus.OUT_READY = 1'b1;
            @(negedge CLK);
            checks++;
            if (bus.OUT_VALID !== 1'b0) begin
                errors++; $display("FAIL flags_drain[%0d] got %b want 0", i, bus.OUT_VALID);
            end
        end
    endtask

    task automatic test_back_pressure();
        @(negedge CLK);
        bus.OUT_READY = 1'b0;
        set_in(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            errors++; $display("FAIL bp_ready_one got %b want 1", bus.IN_READY);
        end
        bus.S = 16'h0002;
        @(negedge CLK);
        checks++;
        if (bus.IN_READY !== 1'b0 || bus.RESULT !== 16'h0001) begin
            errors++;
            $display("FAIL bp_two got rdy=%b res=%h want rdy=0 res=0001", bus.IN_READY, bus.RESULT);
        end
        bus.S = 16'h0003;
        @(negedge CLK);
        checks++;
        if (bus.IN_READY !== 1'b0 || bus.RESULT !== 16'h0001 || bus.OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall got rdy=%b res=%h v=%b want 0 0001 1", bus.IN_READY, bus.RESULT, bus.OUT_VALID);
        end
        bus.OUT_READY = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.RESULT !== 16'h0002 || bus.IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL bp_second got res=%h rdy=%b want 0002 1", bus.RESULT, bus.IN_READY);
        end
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        checks++;
        if (bus.RESULT !== 16'h0003 || bus.OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL bp_third got res=%h v=%b want 0003 1", bus.RESULT, bus.OUT_VALID);
        end
        @(negedge CLK);
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL bp_empty got %b want 0", bus.OUT_VALID);
        end
    endtask

    task automatic test_saturation();
        int   acc;
        int   cyc;
        logic rdy;
        @(negedge CLK);
        CLR_COUNT = 1'b1;
        @(negedge CLK);
        CLR_COUNT = 1'b0;
        checks++;
        if (OF_COUNT !== 8'd0) begin
            errors++; $display("FAIL sat_clear_idle got %0d want 0", OF_COUNT);
        end
        bus.OUT_READY = 1'b1;
        set_in(1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
        acc = 0;
        cyc = 0;
        while (acc < 300 && cyc < 400) begin
            rdy = bus.IN_READY;
            @(negedge CLK);
            cyc++;
            if (rdy) acc++;
            if (acc == 10 && rdy) begin
                checks++;
                if (OF_COUNT !== 8'd10) begin
                    errors++; $display("FAIL sat_count10 got %0d want 10", OF_COUNT);
                end
            end
        end
        bus.IN_VALID = 1'b0;
        checks++;
        if (acc != 300 || cyc != 300) begin
            errors++; $display("FAIL sat_throughput got acc=%0d cyc=%0d want 300 300", acc, cyc);
        end
        checks++;
        if (OF_COUNT !== 8'd255) begin
            errors++; $display("FAIL sat_hold got %0d want 255", OF_COUNT);
        end
        @(negedge CLK);
        CLR_COUNT = 1'b1;
        bus.IN_VALID = 1'b1;
        @(negedge CLK);
        CLR_COUNT = 1'b0;
        checks++;
        if (OF_COUNT !== 8'd0) begin
            errors++; $display("FAIL sat_clear_prio got %0d want 0", OF_COUNT);
        end
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        checks++;
        if (OF_COUNT !== 8'd1) begin
            errors++; $display("FAIL sat_after_clear got %0d want 1", OF_COUNT);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        CLR_COUNT = 1'b1;
        bus.OUT_READY = 1'b0;
        @(negedge CLK);
        CLR_COUNT = 1'b0;
        set_in(1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        bus.S = 16'h8001;
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        checks++;
        if (bus.IN_READY !== 1'b0 || OF_COUNT !== 8'd2 || bus.OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL mid_fill got rdy=%b cnt=%0d v=%b want 0 2 1", bus.IN_READY, OF_COUNT, bus.OUT_VALID);
        end
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL mid_async got v=%b rdy=%b want 0 0", bus.OUT_VALID, bus.IN_READY);
        end
        checks++;
        if (OF_COUNT !== 8'd0 || bus.FLAGS !== 4'h0) begin
            errors++;
            $display("FAIL mid_clear got cnt=%0d flg=%b want 0 0000", OF_COUNT, bus.FLAGS);
        end
        #1 RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.IN_READY !== 1'b1 || bus.OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL mid_release got rdy=%b v=%b want 1 0", bus.IN_READY, bus.OUT_VALID);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_flags();
        test_back_pressure();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/addsub_result_stage.md
# addsub_result_stage

Registered output stage that sits directly downstream of the ripple-carry adder/subtractor. It captures the adder's sum, carry-out and overflow together with the operation type, and derives the architectural flags NF, ZF, CF and OF. A 2-entry valid/ready buffer gives full throughput under back-pressure. The stage also keeps a saturating count of overflowing results for debug and status reads.

## Interface
- DATA_WIDTH, 16, width of sum and RESULT
- OVERFLOW_LOGIC, 1, when 0 the OF input is ignored, FLAGS[0] is always 0 and OF_COUNT stays 0
- COUNT_WIDTH, 8, width of OF_COUNT
- CLK  input  1  single clock, rising edge
- RST_N  input  1  asynchronous, active-low reset
- IN_VALID  input  1  adder result valid
- IN_READY  output  1  stage can accept a result
- S  input  DATA_WIDTH  adder sum
- CF  input  1  raw adder carry-out
- OF  input  1  adder signed overflow
- SUB  input  1  result came from a subtraction (B inverted, Cin=1)
- OUT_VALID  output  1  RESULT/FLAGS valid
- OUT_READY  input  1  consumer accepts
- RESULT  output  DATA_WIDTH  registered sum
- FLAGS  output  4  {NF, ZF, CF, OF}
- OF_COUNT  output  COUNT_WIDTH  saturating count of accepted results with OF=1
- CLR_COUNT  input  1  synchronous clear of OF_COUNT

## Operation
- Accept on IN_VALID & IN_READY; emit on OUT_VALID & OUT_READY. Order is strictly FIFO, with no loss and no duplication.
- Flags are computed at accept time and stored with the entry:
  - NF = S[DATA_WIDTH-1]
  - ZF = (S == 0)
  - CF = CF ^ SUB (for a subtraction this is the borrow: 1 when the minuend is less than the subtrahend, unsigned)
  - OF = OF & (OVERFLOW_LOGIC != 0)
- Storage is a main register (drives the outputs) and a skid register. The state machine is:
  - EMPTY → ONE on accept.
  - ONE → ONE on accept+emit, or on neither.
  - ONE → TWO on accept without emit; the new entry goes to skid.
  - ONE → EMPTY on emit without accept.
  - TWO → ONE on emit; skid moves to main.
  - No accept is possible in TWO.
- When in EMPTY, only accept is possible.
- OUT_VALID = (state != EMPTY).
- IN_READY is a registered signal:
  - Cleared by reset.
  - Set on the first CLK edge after RST_N deasserts.
  - Thereafter equals (next_state != TWO).
- OF_COUNT:
  - Increments by 1 on each accept whose stored OF=1.
  - Holds at 2^COUNT_WIDTH-1 (no wrap).
  - CLR_COUNT has priority: count becomes 0, and an OF accept in the same cycle is not counted.
- RESULT and FLAGS hold stable while OUT_VALID=1 and OUT_READY=0.
- S, CF, OF and SUB are sampled only on accept. Their values at other times are don't-care.

## Timing
- Reset (RST_N low, asynchronous): state EMPTY, OUT_VALID=0, IN_READY=0, RESULT=0, FLAGS=0, OF_COUNT=0, skid cleared.
- Reset mid-operation discards all held entries immediately, without waiting for a clock edge.
- Latency: a result accepted at edge k is presented with OUT_VALID=1 after edge k.
- Throughput: 1 result/cycle while OUT_READY=1.
- IN_READY falls the cycle after the skid fills. It rises the cycle after an emit from TWO. IN_READY never depends combinationally on OUT_READY.
- Back-to-back accept+emit in ONE: RESULT updates every cycle.
- OF_COUNT updates the cycle after the accept or clear edge.

## Test plan
- Add overflow: S=0x8000, CF=0, OF=1, SUB=0 (0x7FFF+0x0001) → RESULT=0x8000, FLAGS=4'b1001, OF_COUNT=1.
- Subtract equal (5-5): S=0x0000, CF=1, OF=0, SUB=1 → RESULT=0x0000, FLAGS=4'b0100 (ZF=1, no borrow).
- Subtract with borrow (3-5): S=0xFFFE, CF=0, OF=0, SUB=1 → FLAGS=4'b1010 (NF=1, CF=1).
- Back-pressure: hold OUT_READY=0 and offer 0x0001, 0x0002, 0x0003 consecutively.
  - Expected: the first two are accepted, IN_READY=0 from the cycle after the second accept, and 0x0003 is stalled.
  - Then raise OUT_READY: output is 0x0001, 0x0002, 0x0003 in order, one per cycle once accepted.
- Saturation/clear: 300 accepts with OF=1 → OF_COUNT=255. Then assert CLR_COUNT on the same cycle as an OF=1 accept → OF_COUNT=0 next cycle.
- Reset mid-operation: fill to TWO with OF_COUNT=2, then pulse RST_N low between edges.
  - Expected immediately: OUT_VALID=0, IN_READY=0, OF_COUNT=0, FLAGS=0.
  - IN_READY=1 after the first edge following release.
